// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
//   Shift-and-add multiplier datapath sitting under the 16-bit control-word
//   FSM. Each cycle it decodes i_ctrl, reads two operands from an 8-entry
//   register file, runs them through a 4-function ALU and optionally writes
//   the result back. Status flags are fed back to the FSM to pick its next
//   state. By convention r0 = product, r1 = multiplicand (shifted left),
//   r2 = multiplier (shifted right).
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous, active-high reset
//   i_load   in   1      r0<=0, r1<=i_a, r2<=i_b, overflow cleared
//   i_a      in   WIDTH  multiplicand
//   i_b      in   WIDTH  multiplier
//   i_ctrl   in   16     control word:
//                          [15:14] alu_op  [13:12] reserved  [11:9] sel_a
//                          [8:6]   sel_b   [5:3]   sel_dst   [2] reserved
//                          [1]     shr2    [0]     w
//   o_result out  WIDTH  r0 (product)
//   mayor    out  1      r[sel_a] > r[sel_b], unsigned
//   paridad  out  1      r2[0]
//   compuor  out  1      r2 == 0
//   o_ovf    out  1      sticky overflow of r0 since last load
//
// There is no handshake: the FSM owns sequencing and the datapath obeys the
// control word every cycle. i_load outranks i_ctrl.
// -----------------------------------------------------------------------------
module mult_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [15:0]      i_ctrl,
   output logic [WIDTH-1:0] o_result,
   output logic             mayor,
   output logic             paridad,
   output logic             compuor,
   output logic             o_ovf
);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_SHR  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   logic [WIDTH-1:0] regs [8];

   logic [1:0]       alu_op;
   logic [2:0]       sel_a;
   logic [2:0]       sel_b;
   logic [2:0]       sel_dst;
   logic             shr2;
   logic             w;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;
   logic             alu_co;

   assign alu_op  = i_ctrl[15:14];
   assign sel_a   = i_ctrl[11:9];
   assign sel_b   = i_ctrl[8:6];
   assign sel_dst = i_ctrl[5:3];
   assign shr2    = i_ctrl[1];
   assign w       = i_ctrl[0];

   // Reserved control bits are decoded nowhere; they are folded here only so
   // the intent of leaving them unused is explicit.
   logic unused_ctrl;
   assign unused_ctrl = ^{i_ctrl[13:12], i_ctrl[2]};

   assign op_a = regs[sel_a];
   assign op_b = regs[sel_b];

   // alu_co carries the bit lost from the WIDTH-bit result: ADD carry-out or
   // the MSB shifted out by SHL. It matters only when r0 is the destination.
   always_comb begin
      alu_res = op_a;
      alu_co  = 1'b0;
      case (alu_op)
         OP_ADD:  {alu_co, alu_res} = {1'b0, op_a} + {1'b0, op_b};
         OP_SHL:  begin
            alu_res = {op_a[WIDTH-2:0], 1'b0};
            alu_co  = op_a[WIDTH-1];
         end
         OP_SHR:  alu_res = {1'b0, op_a[WIDTH-1:1]};
         OP_PASS: alu_res = op_a;
         default: alu_res = op_a;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         o_ovf <= 1'b0;
      end else if (i_load) begin
         regs[0] <= '0;
         regs[1] <= i_a;
         regs[2] <= i_b;
         o_ovf   <= 1'b0;
      end else begin
         if (shr2) regs[2] <= {1'b0, regs[2][WIDTH-1:1]};
         // Placed after the shift so an ALU write to r2 overrides it.
         if (w) begin
            regs[sel_dst] <= alu_res;
            if ((sel_dst == 3'd0) && alu_co) o_ovf <= 1'b1;
         end
      end
   end

   assign o_result = regs[0];
   assign mayor    = (op_a > op_b);
   assign paridad  = regs[2][0];
   assign compuor  = (regs[2] == '0);

endmodule

// File: tb/tb_mult_datapath.sv
module tb_mult_datapath;

  localparam int WIDTH = 8;
  localparam int SW    = WIDTH + 2;  // {result, ovf, compuor}

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SHL  = 2'b01;
  localparam logic [1:0] SHR  = 2'b10;
  localparam logic [1:0] PASS = 2'b11;

  logic             clk;
  logic             rst;
  logic             i_load;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [15:0]      i_ctrl;
  logic [WIDTH-1:0] o_result;
  logic             mayor;
  logic             paridad;
  logic             compuor;
  logic             o_ovf;

  int errors = 0;
  int checks = 0;

  logic [SW-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_res;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[10];

  mult_datapath #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_load   (i_load),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_ctrl   (i_ctrl),
    .o_result (o_result),
    .mayor    (mayor),
    .paridad  (paridad),
    .compuor  (compuor),
    .o_ovf    (o_ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] sa,
                                     input logic [2:0] sb, input logic [2:0] sd,
                                     input logic s2, input logic wr);
    return {op, 2'b00, sa, sb, sd, 1'b0, s2, wr};
  endfunction

  // LSB-first shift-add with an 8-bit multiplicand register: partial
  // products lose bits shifted past the MSB, and only carries out of the
  // product accumulation count as overflow.
  function automatic logic [SW-1:0] exp_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] term;
    logic             ovf;
    prod = '0;
    ovf  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (b[k]) begin
        term = {{WIDTH{1'b0}}, a} << k;
        acc  = {1'b0, prod} + {1'b0, term[WIDTH-1:0]};
        if (acc[WIDTH]) ovf = 1'b1;
        prod = acc[WIDTH-1:0];
      end
    end
    return {prod, ovf, 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [15:0] c);
    i_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [15:0] c);
    i_load = 1'b1;
    i_a    = a;
    i_b    = b;
    step(c);
    i_load = 1'b0;
    i_a    = WIDTH'($urandom_range(0, 255));
    i_b    = WIDTH'($urandom_range(0, 255));
    i_ctrl = 16'h0000;
  endtask

  // Drives the FSM's role: add when the multiplier LSB is set, then shift
  // both operand registers, until the multiplier is exhausted.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [SW-1:0] exp);
    int iter;
    exp_q.push_back(exp);
    do_load(a, b, 16'h0000);
    iter = 0;
    while (!compuor && iter < 2 * WIDTH + 4) begin
      if (paridad) step(mk(ADD, 3'd0, 3'd1, 3'd0, 1'b0, 1'b1));
      step(mk(SHL, 3'd1, 3'd0, 3'd1, 1'b1, 1'b1));
      iter++;
    end
    i_ctrl = 16'h0000;
    if (!compuor) begin
      checks++;
      errors++;
      $display("FAIL mul_timeout a=%0h b=%0h: compuor got 0 expected 1", a, b);
      void'(exp_q.pop_front());
    end else begin
      scoreboard_pop($sformatf("mul %0h*%0h", a, b));
    end
  endtask

  task automatic scoreboard_pop(input string name);
    logic [SW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got %0h expected entry", name, o_result);
    end else begin
      e = exp_q.pop_front();
      check({name, " result"}, 32'(o_result), 32'(e[SW-1:2]));
      check({name, " ovf"}, 32'(o_ovf), 32'(e[1]));
      check({name, " compuor"}, 32'(compuor), 32'(e[0]));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{a: 8'h06, b: 8'h05, exp_res: 8'h1E, exp_ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h02, exp_res: 8'hFE, exp_ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h03, exp_res: 8'h80, exp_ovf: 1'b0};
    vecs[3] = '{a: 8'h0F, b: 8'h11, exp_res: 8'hFF, exp_ovf: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, exp_res: 8'h01, exp_ovf: 1'b1};
    vecs[5] = '{a: 8'h10, b: 8'h10, exp_res: 8'h00, exp_ovf: 1'b0};
    vecs[6] = '{a: 8'h00, b: 8'h07, exp_res: 8'h00, exp_ovf: 1'b0};
    vecs[7] = '{a: 8'h07, b: 8'h00, exp_res: 8'h00, exp_ovf: 1'b0};
    vecs[8] = '{a: 8'h01, b: 8'h80, exp_res: 8'h80, exp_ovf: 1'b0};
    vecs[9] = '{a: 8'h03, b: 8'h81, exp_res: 8'h83, exp_ovf: 1'b0};

    rst    = 1'b1;
    i_load = 1'b0;
    i_a    = '0;
    i_b    = '0;
    i_ctrl = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", 32'(o_result), 32'h0);
    check("reset ovf", 32'(o_ovf), 32'h0);
    check("reset paridad", 32'(paridad), 32'h0);
    check("reset compuor", 32'(compuor), 32'h1);
    check("reset mayor", 32'(mayor), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven multiplies
    for (int i = 0; i < 10; i++)
      run_mul(vecs[i].a, vecs[i].b, {vecs[i].exp_res, vecs[i].exp_ovf, 1'b1});

    // Random multiplies
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      run_mul(ra, rb, exp_mul(ra, rb));
    end

    // Repeated addition 0x80 * 3: the first carry out of r0 sets the flag
    exp_q.push_back({8'h80, 1'b1, 1'b0});
    do_load(8'h80, 8'h03, 16'h0000);
    repeat (3) step(mk(ADD, 3'd0, 3'd1, 3'd0, 1'b0, 1'b1));
    i_ctrl = 16'h0000;
    scoreboard_pop("repadd 80*3");

    // ALU write to r2 wins over shr2 in the same cycle
    do_load(8'h09, 8'h04, 16'h0000);
    step(mk(PASS, 3'd1, 3'd0, 3'd2, 1'b1, 1'b1));
    check("conflict paridad", 32'(paridad), 32'h1);
    step(mk(PASS, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1));
    check("conflict r2", 32'(o_result), 32'h09);

    // shr2 alone, w=0
    do_load(8'h00, 8'h06, 16'h0000);
    step(mk(ADD, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0));
    check("shr2 paridad", 32'(paridad), 32'h1);
    step(mk(PASS, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1));
    check("shr2 r2", 32'(o_result), 32'h03);

    // Load outranks a simultaneous ALU write to r0
    do_load(8'h22, 8'h00, 16'h0000);
    step(mk(PASS, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1));  // r0 = 0x22
    do_load(8'h33, 8'h44, mk(PASS, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1));
    check("load r0", 32'(o_result), 32'h00);
    check("load compuor", 32'(compuor), 32'h0);
    check("load paridad", 32'(paridad), 32'h0);
    step(mk(PASS, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1));
    check("load r1", 32'(o_result), 32'h33);
    step(mk(PASS, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1));
    check("load r2", 32'(o_result), 32'h44);

    // Shifts: SHR into r0, SHL carry into r1 ignored, into r0 flagged
    do_load(8'h81, 8'h01, 16'h0000);
    step(mk(SHR, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1));
    check("shr r0", 32'(o_result), 32'h40);
    step(mk(PASS, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1));
    step(mk(SHL, 3'd1, 3'd0, 3'd1, 1'b0, 1'b1));
    check("shl r1 no ovf", 32'(o_ovf), 32'h0);
    step(mk(SHL, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1));
    check("shl r0", 32'(o_result), 32'h02);
    check("shl r0 ovf", 32'(o_ovf), 32'h1);

    // Async reset mid-multiply
    do_load(8'hC0, 8'h03, 16'h0000);
    for (int k = 3; k < 8; k++) step(mk(PASS, 3'd1, 3'd0, 3'(k), 1'b0, 1'b1));
    step(mk(ADD, 3'd1, 3'd1, 3'd0, 1'b0, 1'b1));
    check("pre-rst ovf", 32'(o_ovf), 32'h1);
    step(mk(SHL, 3'd1, 3'd0, 3'd1, 1'b1, 1'b1));
    i_ctrl = mk(ADD, 3'd0, 3'd1, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst result", 32'(o_result), 32'h0);
    check("rst ovf", 32'(o_ovf), 32'h0);
    check("rst compuor", 32'(compuor), 32'h1);
    i_ctrl = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 3; k < 8; k++) begin
      step(mk(PASS, 3'(k), 3'd0, 3'd0, 1'b0, 1'b1));
      check($sformatf("rst r%0d", k), 32'(o_result), 32'h0);
    end

    // mayor comparisons and NOP hold
    do_load(8'h07, 8'h07, 16'h0000);
    i_ctrl = mk(ADD, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0);
    #1;
    check("mayor 7>7", 32'(mayor), 32'h0);
    do_load(8'h08, 8'h07, 16'h0000);
    i_ctrl = mk(ADD, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0);
    #1;
    check("mayor 8>7", 32'(mayor), 32'h1);
    i_ctrl = mk(ADD, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0);
    #1;
    check("mayor 7>8", 32'(mayor), 32'h0);
    step(mk(PASS, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1));  // r0 = 8
    for (int n = 0; n < 10; n++) step(n[0] ? 16'h3004 : 16'h0000);
    check("nop result", 32'(o_result), 32'h08);
    check("nop paridad", 32'(paridad), 32'h1);
    check("nop compuor", 32'(compuor), 32'h0);
    check("nop mayor", 32'(mayor), 32'h0);
    check("nop ovf", 32'(o_ovf), 32'h0);

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
